// File: rtl/lc3b_types.sv
// Shared LC-3b memory types and arbiter state encodings for the I/D cache arbiter.
package lc3b_types;

    typedef logic [15:0]  lc3b_word;
    typedef logic [127:0] lc3b_cache_line;

    typedef enum logic [1:0] {
        ARB_IDLE    = 2'd0,
        ARB_GRANT_I = 2'd1,
        ARB_GRANT_D = 2'd2
    } arb_state_t;

    typedef enum logic {
        CLIENT_I = 1'b0,
        CLIENT_D = 1'b1
    } arb_client_t;

    function automatic arb_state_t grant_state(input arb_client_t client);
        return (client == CLIENT_D) ? ARB_GRANT_D : ARB_GRANT_I;
    endfunction

endpackage

// File: rtl/cache_arbiter_if.sv
// Bus bundle between the two cache clients, the arbiter and physical memory.
// slave = arbiter side, master = clients + memory side.
interface cache_arbiter_if;
    import lc3b_types::*;

    logic           i_arb_mem_read;
    logic           i_arb_mem_write;
    lc3b_word       i_arb_mem_address;
    lc3b_cache_line i_arb_mem_wdata;
    logic           i_arb_mem_resp;
    lc3b_cache_line i_arb_mem_rdata;

    logic           d_arb_mem_read;
    logic           d_arb_mem_write;
    lc3b_word       d_arb_mem_address;
    lc3b_cache_line d_arb_mem_wdata;
    logic           d_arb_mem_resp;
    lc3b_cache_line d_arb_mem_rdata;

    logic           pmem_read;
    logic           pmem_write;
    lc3b_word       pmem_address;
    lc3b_cache_line pmem_wdata;
    logic           pmem_resp;
    lc3b_cache_line pmem_rdata;

    modport slave (
        input  i_arb_mem_read, i_arb_mem_write, i_arb_mem_address, i_arb_mem_wdata,
        output i_arb_mem_resp, i_arb_mem_rdata,
        input  d_arb_mem_read, d_arb_mem_write, d_arb_mem_address, d_arb_mem_wdata,
        output d_arb_mem_resp, d_arb_mem_rdata,
        output pmem_read, pmem_write, pmem_address, pmem_wdata,
        input  pmem_resp, pmem_rdata
    );

    modport master (
        output i_arb_mem_read, i_arb_mem_write, i_arb_mem_address, i_arb_mem_wdata,
        input  i_arb_mem_resp, i_arb_mem_rdata,
        output d_arb_mem_read, d_arb_mem_write, d_arb_mem_address, d_arb_mem_wdata,
        input  d_arb_mem_resp, d_arb_mem_rdata,
        input  pmem_read, pmem_write, pmem_address, pmem_wdata,
        output pmem_resp, pmem_rdata
    );

endinterface

// File: rtl/cache_arbiter_control.sv
// Grant FSM and last_grant history for the cache arbiter.
// ARB_ROUND_ROBIN_EN: ties go to the client not granted last; otherwise D_FIRST picks.
module arbiter_control
    import lc3b_types::*;
#(
    parameter bit D_FIRST = 1'b1
) (
    input  logic       clk,
    input  logic       reset_n,
    input  logic       i_i_req,
    input  logic       i_d_req,
    input  logic       i_pmem_resp,
    output arb_state_t o_state
);

    arb_state_t  r_state;
    arb_state_t  w_state_next;
    arb_client_t r_last_grant;
    arb_client_t w_last_grant_next;
    arb_client_t w_tie_winner;

`ifdef ARB_ROUND_ROBIN_EN
    localparam bit unused_d_first = D_FIRST;
    assign w_tie_winner = (r_last_grant == CLIENT_I) ? CLIENT_D : CLIENT_I;
`else
    // History is kept for observability only; it never steers a tie here.
    logic w_unused_last_grant;
    assign w_unused_last_grant = r_last_grant;
    assign w_tie_winner        = D_FIRST ? CLIENT_D : CLIENT_I;
`endif

    always_comb begin
        w_state_next      = r_state;
        w_last_grant_next = r_last_grant;
        case (r_state)
            ARB_IDLE: begin
                if (i_i_req && i_d_req) begin
                    w_state_next      = grant_state(w_tie_winner);
                    w_last_grant_next = w_tie_winner;
                end else if (i_d_req) begin
                    w_state_next      = ARB_GRANT_D;
                    w_last_grant_next = CLIENT_D;
                end else if (i_i_req) begin
                    w_state_next      = ARB_GRANT_I;
                    w_last_grant_next = CLIENT_I;
                end
            end
            // A grant is held until memory answers, regardless of client requests.
            ARB_GRANT_I, ARB_GRANT_D: begin
                if (i_pmem_resp) begin
                    w_state_next = ARB_IDLE;
                end
            end
            default: begin
                w_state_next = ARB_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_state      <= ARB_IDLE;
            r_last_grant <= CLIENT_I;
        end else begin
            r_state      <= w_state_next;
            r_last_grant <= w_last_grant_next;
        end
    end

    assign o_state = r_state;

endmodule

// File: rtl/cache_arbiter.sv
// Two-client (I-cache / D-cache) arbiter onto a single physical memory port.
// Tie policy selectable by ARB_ROUND_ROBIN_EN (see arbiter_control).
module cache_arbiter
    import lc3b_types::*;
#(
    parameter bit D_FIRST = 1'b1
) (
    input  logic            clk,
    input  logic            reset_n,
    cache_arbiter_if.slave  bus
);

    logic       w_i_req;
    logic       w_d_req;
    arb_state_t w_state;

    assign w_i_req = bus.i_arb_mem_read | bus.i_arb_mem_write;
    assign w_d_req = bus.d_arb_mem_read | bus.d_arb_mem_write;

    arbiter_control #(
        .D_FIRST (D_FIRST)
    ) u_control (
        .clk         (clk),
        .reset_n     (reset_n),
        .i_i_req     (w_i_req),
        .i_d_req     (w_d_req),
        .i_pmem_resp (bus.pmem_resp),
        .o_state     (w_state)
    );

    // Pure combinational steering so a response reaches the client in the same cycle.
    always_comb begin
        bus.pmem_read      = 1'b0;
        bus.pmem_write     = 1'b0;
        bus.pmem_address   = '0;
        bus.pmem_wdata     = '0;
        bus.i_arb_mem_resp = 1'b0;
        bus.d_arb_mem_resp = 1'b0;
        case (w_state)
            ARB_GRANT_I: begin
                bus.pmem_read      = bus.i_arb_mem_read;
                bus.pmem_write     = bus.i_arb_mem_write;
                bus.pmem_address   = bus.i_arb_mem_address;
                bus.pmem_wdata     = bus.i_arb_mem_wdata;
                bus.i_arb_mem_resp = bus.pmem_resp;
            end
            ARB_GRANT_D: begin
                bus.pmem_read      = bus.d_arb_mem_read;
                bus.pmem_write     = bus.d_arb_mem_write;
                bus.pmem_address   = bus.d_arb_mem_address;
                bus.pmem_wdata     = bus.d_arb_mem_wdata;
                bus.d_arb_mem_resp = bus.pmem_resp;
            end
            default: ;
        endcase
    end

    assign bus.i_arb_mem_rdata = bus.pmem_rdata;
    assign bus.d_arb_mem_rdata = bus.pmem_rdata;

endmodule

// File: tb/tb_cache_arbiter.sv
// Scoreboard bench for cache_arbiter: directed client traffic, a latency-programmable
// memory model, and a monitor that checks each response against a queue of expectations.
module tb_cache_arbiter;
    import lc3b_types::*;

    localparam int TIMEOUT = 200;

    typedef struct {
        arb_client_t    client;
        logic           rd;
        logic           wr;
        lc3b_word       addr;
        lc3b_cache_line wdata;
        lc3b_cache_line rdata;
    } exp_t;

    logic clk;
    logic reset_n;
    int   n_checks = 0;
    int   n_pass   = 0;
    int   mem_lat  = 3;
    exp_t exp_q[$];

    cache_arbiter_if bus_if();

    cache_arbiter #(.D_FIRST(1'b1)) dut (
        .clk     (clk),
        .reset_n (reset_n),
        .bus     (bus_if)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation still running, required finish");
        $fatal(1, "watchdog expired");
    end

    task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %h required %h", name, act, exp);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic exp_t mk(input arb_client_t c, input logic rd, input logic wr,
                                input lc3b_word a, input lc3b_cache_line wd, input lc3b_cache_line rdat);
        exp_t e;
        e.client = c; e.rd = rd; e.wr = wr; e.addr = a; e.wdata = wd; e.rdata = rdat;
        return e;
    endfunction

    // Memory model: answers once the request has been visible for mem_lat cycles.
    initial begin
        int cnt;
        cnt = 0;
        bus_if.pmem_resp = 1'b0;
        forever begin
            tick();
            if (bus_if.pmem_resp) begin
                bus_if.pmem_resp = 1'b0;
                cnt = 0;
            end else if (bus_if.pmem_read || bus_if.pmem_write) begin
                cnt++;
                if (cnt >= mem_lat) begin
                    bus_if.pmem_resp = 1'b1;
                    cnt = 0;
                end
            end else begin
                cnt = 0;
            end
        end
    end

    // Monitor: every response pops one expectation; responses must last one cycle.
    initial begin
        exp_t e;
        logic chk_i_drop, chk_d_drop;
        chk_i_drop = 1'b0;
        chk_d_drop = 1'b0;
        forever begin
            @(negedge clk);
            if (chk_i_drop) begin
                check("i_resp_one_cycle", bus_if.i_arb_mem_resp, 1'b0);
                chk_i_drop = 1'b0;
            end
            if (chk_d_drop) begin
                check("d_resp_one_cycle", bus_if.d_arb_mem_resp, 1'b0);
                chk_d_drop = 1'b0;
            end
            if (bus_if.i_arb_mem_resp || bus_if.d_arb_mem_resp) begin
                if (exp_q.size() == 0) begin
                    n_checks++;
                    $display("FAIL unexpected_resp: i_resp=%b d_resp=%b, required no response",
                             bus_if.i_arb_mem_resp, bus_if.d_arb_mem_resp);
                end else begin
                    e = exp_q.pop_front();
                    check("resp_client", {bus_if.i_arb_mem_resp, bus_if.d_arb_mem_resp},
                          (e.client == CLIENT_D) ? 2'b01 : 2'b10);
                    check("pmem_read", bus_if.pmem_read, e.rd);
                    check("pmem_write", bus_if.pmem_write, e.wr);
                    check("pmem_address", bus_if.pmem_address, e.addr);
                    check("pmem_wdata", bus_if.pmem_wdata, e.wdata);
                    if (e.client == CLIENT_D) begin
                        check("d_rdata", bus_if.d_arb_mem_rdata, e.rdata);
                        chk_d_drop = 1'b1;
                    end else begin
                        check("i_rdata", bus_if.i_arb_mem_rdata, e.rdata);
                        chk_i_drop = 1'b1;
                    end
                    $display("txn client=%s addr=%h rd=%b wr=%b rdata=%h",
                             (e.client == CLIENT_D) ? "D" : "I", bus_if.pmem_address,
                             bus_if.pmem_read, bus_if.pmem_write, bus_if.pmem_rdata);
                end
            end
        end
    end

    task automatic i_txn(input logic rd, input logic wr, input lc3b_word a, input lc3b_cache_line wd);
        int k;
        bus_if.i_arb_mem_read    = rd;
        bus_if.i_arb_mem_write   = wr;
        bus_if.i_arb_mem_address = a;
        bus_if.i_arb_mem_wdata   = wd;
        k = 0;
        do begin
            @(negedge clk);
            k++;
        end while (!bus_if.i_arb_mem_resp && k < TIMEOUT);
        if (!bus_if.i_arb_mem_resp) begin
            n_checks++;
            $display("FAIL i_txn_timeout: no i resp after %0d cycles, required resp=1", k);
        end
        tick();
        bus_if.i_arb_mem_read  = 1'b0;
        bus_if.i_arb_mem_write = 1'b0;
    endtask

    task automatic d_txn(input logic rd, input logic wr, input lc3b_word a, input lc3b_cache_line wd);
        int k;
        bus_if.d_arb_mem_read    = rd;
        bus_if.d_arb_mem_write   = wr;
        bus_if.d_arb_mem_address = a;
        bus_if.d_arb_mem_wdata   = wd;
        k = 0;
        do begin
            @(negedge clk);
            k++;
        end while (!bus_if.d_arb_mem_resp && k < TIMEOUT);
        if (!bus_if.d_arb_mem_resp) begin
            n_checks++;
            $display("FAIL d_txn_timeout: no d resp after %0d cycles, required resp=1", k);
        end
        tick();
        bus_if.d_arb_mem_read  = 1'b0;
        bus_if.d_arb_mem_write = 1'b0;
    endtask

    task automatic pulse_reset();
        reset_n = 1'b0;
        tick();
        reset_n = 1'b1;
        tick();
    endtask

    initial begin
        lc3b_cache_line line_a5, line_w, line_r2;
        int k;
        line_a5 = {16{8'hA5}};
        line_w  = 128'h0123456789ABCDEF0123456789ABCDEF;
        line_r2 = 128'hDEADBEEF_0BADF00D_CAFEBABE_12345678;

        bus_if.i_arb_mem_read = 1'b0; bus_if.i_arb_mem_write = 1'b0;
        bus_if.i_arb_mem_address = '0; bus_if.i_arb_mem_wdata = '0;
        bus_if.d_arb_mem_read = 1'b0; bus_if.d_arb_mem_write = 1'b0;
        bus_if.d_arb_mem_address = '0; bus_if.d_arb_mem_wdata = '0;
        bus_if.pmem_rdata = line_a5;
        reset_n = 1'b0;

        // Reset: requests are ignored, outputs low, rdata still passes through.
        bus_if.i_arb_mem_read = 1'b1;
        bus_if.d_arb_mem_write = 1'b1;
        repeat (3) tick();
        check("rst_pmem_read", bus_if.pmem_read, 1'b0);
        check("rst_pmem_write", bus_if.pmem_write, 1'b0);
        check("rst_i_resp", bus_if.i_arb_mem_resp, 1'b0);
        check("rst_d_resp", bus_if.d_arb_mem_resp, 1'b0);
        check("rst_i_rdata_pass", bus_if.i_arb_mem_rdata, line_a5);
        check("rst_d_rdata_pass", bus_if.d_arb_mem_rdata, line_a5);
        bus_if.i_arb_mem_read = 1'b0;
        bus_if.d_arb_mem_write = 1'b0;
        reset_n = 1'b1;
        tick();

        // I read 0x1230, 3-cycle memory, one cycle of added latency.
        mem_lat = 3;
        exp_q.push_back(mk(CLIENT_I, 1'b1, 1'b0, 16'h1230, '0, line_a5));
        fork
            i_txn(1'b1, 1'b0, 16'h1230, '0);
            begin
                @(negedge clk);
                check("lat_idle_read", bus_if.pmem_read, 1'b0);
                @(negedge clk);
                check("lat_grant_read", bus_if.pmem_read, 1'b1);
                check("lat_grant_addr", bus_if.pmem_address, 16'h1230);
                check("lat_d_resp_low", bus_if.d_arb_mem_resp, 1'b0);
            end
        join
        tick();

        // D write 0x4440; state returns to IDLE right after the response.
        mem_lat = 2;
        bus_if.pmem_rdata = line_r2;
        exp_q.push_back(mk(CLIENT_D, 1'b0, 1'b1, 16'h4440, line_w, line_r2));
        d_txn(1'b0, 1'b1, 16'h4440, line_w);
        @(negedge clk);
        check("post_write_idle", bus_if.pmem_write, 1'b0);
        tick();

        // Read and write asserted together are forwarded unchanged.
        exp_q.push_back(mk(CLIENT_I, 1'b1, 1'b1, 16'h0BEE, line_w, line_r2));
        i_txn(1'b1, 1'b1, 16'h0BEE, line_w);
        tick();

        // Simultaneous requests twice from a fresh reset: D wins, I follows after one idle cycle.
        pulse_reset();
        for (int rep = 0; rep < 2; rep++) begin
            exp_q.push_back(mk(CLIENT_D, 1'b1, 1'b0, 16'h5000, '0, line_r2));
            exp_q.push_back(mk(CLIENT_I, 1'b1, 1'b0, 16'h6000, '0, line_r2));
            fork
                d_txn(1'b1, 1'b0, 16'h5000, '0);
                i_txn(1'b1, 1'b0, 16'h6000, '0);
                begin
                    k = 0;
                    do begin
                        @(negedge clk);
                        k++;
                    end while (!bus_if.d_arb_mem_resp && k < TIMEOUT);
                    @(negedge clk);
                    check("tie_idle_gap", bus_if.pmem_read, 1'b0);
                    @(negedge clk);
                    check("tie_i_after_gap", bus_if.pmem_address, 16'h6000);
                end
            join
            tick();
        end

        // D arrives while I holds the grant: the grant is not revoked.
        mem_lat = 4;
        exp_q.push_back(mk(CLIENT_I, 1'b1, 1'b0, 16'h2000, '0, line_r2));
        exp_q.push_back(mk(CLIENT_D, 1'b1, 1'b0, 16'h3000, '0, line_r2));
        fork
            i_txn(1'b1, 1'b0, 16'h2000, '0);
            begin
                tick();
                tick();
                d_txn(1'b1, 1'b0, 16'h3000, '0);
            end
            begin
                tick();
                tick();
                for (int c = 0; c < 3; c++) begin
                    @(negedge clk);
                    check("hold_i_addr", bus_if.pmem_address, 16'h2000);
                    tick();
                end
                @(negedge clk);
                check("hold_idle_gap", bus_if.pmem_read, 1'b0);
                tick();
                @(negedge clk);
                check("hold_d_granted", bus_if.pmem_address, 16'h3000);
            end
        join
        tick();

        // Both clients issue two back-to-back transactions each.
        mem_lat = 2;
        pulse_reset();
`ifdef ARB_ROUND_ROBIN_EN
        exp_q.push_back(mk(CLIENT_D, 1'b1, 1'b0, 16'h0A00, '0, line_r2));
        exp_q.push_back(mk(CLIENT_I, 1'b1, 1'b0, 16'h0C00, '0, line_r2));
        exp_q.push_back(mk(CLIENT_D, 1'b1, 1'b0, 16'h0B00, '0, line_r2));
        exp_q.push_back(mk(CLIENT_I, 1'b1, 1'b0, 16'h0D00, '0, line_r2));
`else
        exp_q.push_back(mk(CLIENT_D, 1'b1, 1'b0, 16'h0A00, '0, line_r2));
        exp_q.push_back(mk(CLIENT_D, 1'b1, 1'b0, 16'h0B00, '0, line_r2));
        exp_q.push_back(mk(CLIENT_I, 1'b1, 1'b0, 16'h0C00, '0, line_r2));
        exp_q.push_back(mk(CLIENT_I, 1'b1, 1'b0, 16'h0D00, '0, line_r2));
`endif
        fork
            begin
                d_txn(1'b1, 1'b0, 16'h0A00, '0);
                d_txn(1'b1, 1'b0, 16'h0B00, '0);
            end
            begin
                i_txn(1'b1, 1'b0, 16'h0C00, '0);
                i_txn(1'b1, 1'b0, 16'h0D00, '0);
            end
        join
        tick();

        // Reset during GRANT_D abandons the transaction.
        mem_lat = 5;
        bus_if.d_arb_mem_write   = 1'b1;
        bus_if.d_arb_mem_address = 16'h7770;
        bus_if.d_arb_mem_wdata   = line_w;
        tick();
        @(negedge clk);
        check("rst_mid_write_before", bus_if.pmem_write, 1'b1);
        #2;
        reset_n = 1'b0;
        #1;
        check("rst_mid_write_drop", bus_if.pmem_write, 1'b0);
        check("rst_mid_read_drop", bus_if.pmem_read, 1'b0);
        check("rst_mid_d_resp", bus_if.d_arb_mem_resp, 1'b0);
        bus_if.d_arb_mem_write = 1'b0;
        tick();
        tick();
        reset_n = 1'b1;
        k = 0;
        for (int c = 0; c < 8; c++) begin
            @(negedge clk);
            if (bus_if.d_arb_mem_resp) k++;
        end
        check("rst_no_late_d_resp", k, 0);
        tick();
        mem_lat = 2;
        exp_q.push_back(mk(CLIENT_I, 1'b1, 1'b0, 16'h1111, '0, line_r2));
        fork
            i_txn(1'b1, 1'b0, 16'h1111, '0);
            begin
                @(negedge clk);
                check("post_rst_idle", bus_if.pmem_read, 1'b0);
                @(negedge clk);
                check("post_rst_grant_addr", bus_if.pmem_address, 16'h1111);
            end
        join

        repeat (5) tick();
        check("scoreboard_drained", exp_q.size(), 0);
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
